approx_mul_err_monitor: RTL

- In-hardware error monitor for approximate multipliers; the on-chip counterpart of our software error sweeps.
- Takes (a, b, approx_product) samples over a valid/ready handshake.
- Computes the exact product with a sequential shift-add engine, compares it with the approximate product, and accumulates mismatch count, total count, error-distance sum and max error distance.
- Sits beside an approximate multiplier (e.g. an approximate Wallace tree) in the CNN datapath and is read by the host for error characterisation.

---
 rtl/approx_mul_pkg.sv | 20 ++
 rtl/seq_mul_ref.sv | 48 ++++
 rtl/approx_mul_err_monitor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg: shared defaults, FSM state type and saturating add for the approximate multiplier error monitor
package approx_mul_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 32;
    localparam int ACC_W_DEF = 48;
    localparam int SAT_W     = 64;

    typedef enum logic [1:0] {IDLE, MUL, CMP} state_t;

    // Clamps x + y to 2**n - 1; on clamp bit SAT_W is set, so any set bit at or above n flags saturation.
    function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] x, input logic [SAT_W-1:0] y, input int n);
        logic [SAT_W:0] s;
        logic [SAT_W:0] m;
        s = {1'b0, x} + {1'b0, y};
        m = ((SAT_W+1)'(1) << n) - (SAT_W+1)'(1);
        return (s > m) ? {1'b1, m[SAT_W-1:0]} : {1'b0, s[SAT_W-1:0]};
    endfunction

endpackage

// File: rtl/seq_mul_ref.sv
// seq_mul_ref: exact unsigned shift-add multiplier, one partial product per cycle over WIDTH cycles
module seq_mul_ref #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    idx;

    assign busy = cnt != '0;
    // done marks the cycle whose edge adds the last partial product
    assign done = cnt == CW'(1);
    assign idx  = CW'(WIDTH) - cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            cnt  <= '0;
            prod <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (start) begin
            a_q  <= a;
            b_q  <= b;
            cnt  <= CW'(WIDTH);
            prod <= '0;
        end else if (busy) begin
            prod <= b_q[0] ? prod + ({{WIDTH{1'b0}}, a_q} << idx) : prod;
            b_q  <= b_q >> 1;
            cnt  <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor: compares approximate products with an exact shift-add product and accumulates error statistics
// Optional ERR_MON_BIAS_EN adds under_cnt/over_cnt bias counters.
module approx_mul_err_monitor
    import approx_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2*WIDTH-1:0] in_approx,
    output logic               done_valid,
    output logic               done_mismatch,
    output logic [2*WIDTH-1:0] done_ed,
    output logic [CNT_W-1:0]   total_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [ACC_W-1:0]   ed_sum,
    output logic [2*WIDTH-1:0] ed_max,
    output logic               sat
`ifdef ERR_MON_BIAS_EN
    ,
    output logic [CNT_W-1:0]   under_cnt,
    output logic [CNT_W-1:0]   over_cnt
`endif
);

    localparam int PW = 2 * WIDTH;

    state_t         state;
    logic [PW-1:0]  approx_q;
    logic [PW-1:0]  exact;
    logic [PW-1:0]  ed;
    logic           mul_start;
    logic           mul_busy;
    logic           mul_done;
    logic           ovf;
    logic [SAT_W:0] tot_n;
    logic [SAT_W:0] err_n;
    logic [SAT_W:0] sum_n;

    // clr wins over a simultaneous handshake
    assign mul_start = in_valid && in_ready && !clr;

    seq_mul_ref #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .start (mul_start),
        .a     (in_a),
        .b     (in_b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (exact)
    );

    assign ed    = exact >= approx_q ? exact - approx_q : approx_q - exact;
    assign tot_n = sat_add(SAT_W'(total_cnt), SAT_W'(1), CNT_W);
    assign err_n = sat_add(SAT_W'(err_cnt), SAT_W'(ed != '0), CNT_W);
    assign sum_n = sat_add(SAT_W'(ed_sum), SAT_W'(ed), ACC_W);

`ifdef ERR_MON_BIAS_EN
    logic [SAT_W:0] und_n;
    logic [SAT_W:0] ovr_n;
    assign und_n = sat_add(SAT_W'(under_cnt), SAT_W'(exact > approx_q), CNT_W);
    assign ovr_n = sat_add(SAT_W'(over_cnt), SAT_W'(approx_q > exact), CNT_W);
    assign ovf   = |{tot_n[SAT_W:CNT_W], err_n[SAT_W:CNT_W], sum_n[SAT_W:ACC_W], und_n[SAT_W:CNT_W], ovr_n[SAT_W:CNT_W]};
`else
    assign ovf   = |{tot_n[SAT_W:CNT_W], err_n[SAT_W:CNT_W], sum_n[SAT_W:ACC_W]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            approx_q      <= '0;
            done_valid    <= 1'b0;
            done_mismatch <= 1'b0;
            done_ed       <= '0;
            total_cnt     <= '0;
            err_cnt       <= '0;
            ed_sum        <= '0;
            ed_max        <= '0;
            sat           <= 1'b0;
`ifdef ERR_MON_BIAS_EN
            under_cnt     <= '0;
            over_cnt      <= '0;
`endif
        end else if (clr) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            approx_q      <= '0;
            done_valid    <= 1'b0;
            done_mismatch <= 1'b0;
            done_ed       <= '0;
            total_cnt     <= '0;
            err_cnt       <= '0;
            ed_sum        <= '0;
            ed_max        <= '0;
            sat           <= 1'b0;
`ifdef ERR_MON_BIAS_EN
            under_cnt     <= '0;
            over_cnt      <= '0;
`endif
        end else begin
            done_valid <= 1'b0;
            case (state)
                IDLE: if (mul_start) begin
                    approx_q <= in_approx;
                    in_ready <= 1'b0;
                    state    <= MUL;
                end
                MUL: if (mul_done || !mul_busy) state <= CMP;
                CMP: begin
                    done_valid    <= 1'b1;
                    done_mismatch <= ed != '0;
                    done_ed       <= ed;
                    total_cnt     <= tot_n[CNT_W-1:0];
                    err_cnt       <= err_n[CNT_W-1:0];
                    ed_sum        <= sum_n[ACC_W-1:0];
                    ed_max        <= ed > ed_max ? ed : ed_max;
                    sat           <= sat | ovf;
`ifdef ERR_MON_BIAS_EN
                    under_cnt     <= und_n[CNT_W-1:0];
                    over_cnt      <= ovr_n[CNT_W-1:0];
`endif
                    in_ready      <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
